sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single 16-bit asynchronous pixel/asset SRAM between two requesters.
- Video requester: the sprite pixel fetch path. It is latency-critical and has high priority.
- Host requester: the sprite/asset loader. It can read and write, and has low priority with starvation protection.
- Owns every SRAM pin and sequences fixed 2-cycle read and write accesses.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
STARVE_LIMIT, 8, max consecutive video grants while host is pending before the host is forced a grant

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
vid_req  in  1  video read request
vid_addr  in  ADDR_W  video read address
vid_ack  out  1  one-cycle pulse: video request accepted
vid_rdata  out  DATA_W  video read data
vid_rvalid  out  1  one-cycle pulse: vid_rdata valid
host_req  in  1  host request
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle pulse: host request accepted
host_rdata  out  DATA_W  host read data
host_rvalid  out  1  one-cycle pulse: host_rdata valid
sram_addr  out  ADDR_W  SRAM address
sram_dq_in  in  DATA_W  SRAM data bus, read side
sram_dq_out  out  DATA_W  SRAM data bus, write side
sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low

Behaviour:
- All outputs are registered. Reset asserted (reset=0) forces the following immediately, without waiting for a clock edge:
  - state=IDLE; starve counter=0; sram_addr=0; sram_dq_out=0
  - sram_dq_oe=0; sram_ce_n=1; sram_oe_n=1; sram_we_n=1
  - vid_ack, vid_rvalid, host_ack, host_rvalid = 0; vid_rdata, host_rdata = 0
- States: IDLE, RD1, RD2, WR1, WR2, TURN.
- Arbitration edges: a clock edge at which state is IDLE, RD2, WR2 or TURN. Requests are sampled only at these edges.
- Grant rule at an arbitration edge:
  - If both req are low, go to IDLE.
  - Otherwise video wins, unless host_req=1 and starve counter = STARVE_LIMIT; in that case host wins.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each video grant made while host_req=1.
  - Clears on a host grant, or on any arbitration edge where host_req=0.
- Granting edge:
  - Registers the address (and wdata for writes).
  - The winner's ack is 1 for exactly the next cycle.
  - Next state is RD1 for a read or WR1 for a write.
- Read sequence:
  - RD1 and RD2: ce_n=0, oe_n=0, dq_oe=0, addr held.
  - At the edge leaving RD2, sram_dq_in is captured into the owner's rdata, and that owner's rvalid is 1 for one cycle.
  - Latency: request sampled at edge E0 → ack in cycle E0..E1 → rvalid in cycle E2..E3.
- Write sequence:
  - WR1: ce_n=0, dq_oe=1, we_n=0.
  - WR2: we_n=1, with addr and dq still driven (hold).
  - No rvalid is produced for a write.
- Turnaround:
  - If WR2 would be followed by a read grant, the arbiter goes to TURN for one cycle instead.
  - TURN: ce_n=1, dq_oe=0, oe_n=1.
  - TURN is itself an arbitration edge; the read is granted from TURN.
  - A write following a write, or any access following a read, needs no TURN.
- Bus-driving rules:
  - dq_oe=1 only in WR1 and WR2.
  - oe_n=0 only in RD1 and RD2.
  - we_n=0 only in WR1.
  - In IDLE: ce_n=1, oe_n=1, we_n=1, dq_oe=0.
- Throughput: back-to-back accesses, one per 2 cycles, with no IDLE between them while requests are held.
- Requester rules:
  - Hold req, addr, we and wdata stable until ack.
  - To issue a next access, update the request fields during the cycle after ack; they are sampled at the following arbitration edge.
  - Dropping req before ack is allowed; the request is simply not granted.
- Reset mid-access: the access is aborted and we_n returns high asynchronously. No ack or rvalid is ever issued for the aborted access.
- Address width: no wrap or arithmetic; addresses pass through unchanged.

Test Plan:
- Reset=0 for 3 cycles with requests active → every output holds its reset value, with sram_we_n=1 and sram_dq_oe=0 throughout.
- vid_req with vid_addr=0x00010 for one sample; SRAM model returns 0xBEEF → vid_ack 1 cycle after sample, sram_oe_n=0 for 2 cycles, vid_rvalid with vid_rdata=0xBEEF 3 cycles after sample.
- vid_req and host_req (read, 0x00200) asserted in the same cycle → video granted first, host granted at the next arbitration edge, rvalids 2 cycles apart.
- vid_req held high continuously, host_req held, STARVE_LIMIT=8 → 8 video grants, host takes the 9th grant, then video resumes; counter returns to 0.
- Host write addr=0x12345 data=0xA5A5, with vid_req pending → we_n=0 for exactly 1 cycle, dq_oe=1 for 2 cycles, one TURN cycle, then video RD1; SRAM model holds 0xA5A5 at 0x12345.
- Reset=0 asserted during RD1 of a video read → outputs return to reset values before the next edge, and no vid_rvalid is ever produced for that read.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the shared asynchronous pixel/asset SRAM.
// Video reads win by default; the host is forced a grant after STARVE_LIMIT video grants.
module sram_arbiter #(
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_rvalid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD1  = 3'd1,
      RD2  = 3'd2,
      WR1  = 3'd3,
      WR2  = 3'd4,
      TURN = 3'd5
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] starve_r, starve_s;
   logic             host_owner_r, host_owner_s;
   logic             grant_vid_s, grant_host_s;
   logic             host_wins_s, grant_write_s;
   logic             rd_done_s;
   logic             ce_n_s, oe_n_s, we_n_s, dq_oe_s;

   // Next-state, grant selection and starvation counting
   always_comb begin
      state_s       = state_r;
      starve_s      = starve_r;
      host_owner_s  = host_owner_r;
      grant_vid_s   = 1'b0;
      grant_host_s  = 1'b0;
      host_wins_s   = host_req && (!vid_req || (starve_r == STARVE_MAX));
      grant_write_s = host_wins_s && host_we;
      case (state_r)
         RD1: state_s = RD2;
         WR1: state_s = WR2;
         IDLE, RD2, WR2, TURN: begin
            if (!vid_req && !host_req) begin
               state_s = IDLE;
            end else if ((state_r == WR2) && !grant_write_s) begin
               // bus must float for a cycle before the SRAM may drive it
               state_s = TURN;
            end else begin
               state_s      = grant_write_s ? WR1 : RD1;
               host_owner_s = host_wins_s;
               grant_host_s = host_wins_s;
               grant_vid_s  = !host_wins_s;
            end
            if (!host_req) begin
               starve_s = {CNT_W{1'b0}};
            end else if (grant_host_s) begin
               starve_s = {CNT_W{1'b0}};
            end else if (grant_vid_s && (starve_r != STARVE_MAX)) begin
               starve_s = starve_r + CNT_W'(1);
            end else begin
               starve_s = starve_r;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // SRAM strobe decode for the state being entered, so the pins are registered
   always_comb begin
      ce_n_s  = 1'b1;
      oe_n_s  = 1'b1;
      we_n_s  = 1'b1;
      dq_oe_s = 1'b0;
      case (state_s)
         RD1, RD2: begin
            ce_n_s = 1'b0;
            oe_n_s = 1'b0;
         end
         WR1: begin
            ce_n_s  = 1'b0;
            we_n_s  = 1'b0;
            dq_oe_s = 1'b1;
         end
         WR2: begin
            ce_n_s  = 1'b0;
            dq_oe_s = 1'b1;
         end
         default: begin
            ce_n_s  = 1'b1;
            dq_oe_s = 1'b0;
         end
      endcase
   end

   assign rd_done_s = (state_r == RD2);

   // Control state, strobes and handshake pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         starve_r     <= {CNT_W{1'b0}};
         host_owner_r <= 1'b0;
         vid_ack      <= 1'b0;
         host_ack     <= 1'b0;
         vid_rvalid   <= 1'b0;
         host_rvalid  <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_dq_oe   <= 1'b0;
      end else begin
         state_r      <= state_s;
         starve_r     <= starve_s;
         host_owner_r <= host_owner_s;
         vid_ack      <= grant_vid_s;
         host_ack     <= grant_host_s;
         vid_rvalid   <= rd_done_s && !host_owner_r;
         host_rvalid  <= rd_done_s && host_owner_r;
         sram_ce_n    <= ce_n_s;
         sram_oe_n    <= oe_n_s;
         sram_we_n    <= we_n_s;
         sram_dq_oe   <= dq_oe_s;
      end
   end

   // Address, write data and read data capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sram_addr   <= {ADDR_W{1'b0}};
         sram_dq_out <= {DATA_W{1'b0}};
         vid_rdata   <= {DATA_W{1'b0}};
         host_rdata  <= {DATA_W{1'b0}};
      end else begin
         if (grant_vid_s) begin
            sram_addr <= vid_addr;
         end else if (grant_host_s) begin
            sram_addr <= host_addr;
         end
         if (grant_host_s && grant_write_s) begin
            sram_dq_out <= host_wdata;
         end
         if (rd_done_s && !host_owner_r) begin
            vid_rdata <= sram_dq_in;
         end
         if (rd_done_s && host_owner_r) begin
            host_rdata <= sram_dq_in;
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and read-data scoreboards.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        vid_req = 1'b0;
   logic [19:0] vid_addr = 20'h0;
   logic        vid_ack;
   logic [15:0] vid_rdata;
   logic        vid_rvalid;
   logic        host_req = 1'b0;
   logic        host_we = 1'b0;
   logic [19:0] host_addr = 20'h0;
   logic [15:0] host_wdata = 16'h0;
   logic        host_ack;
   logic [15:0] host_rdata;
   logic        host_rvalid;
   logic [19:0] sram_addr;
   logic [15:0] sram_dq_in = 16'h0;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;

   int checks = 0;
   int failures = 0;
   logic [15:0] mem [int];
   logic [15:0] vq [$];
   logic [15:0] hq [$];

   sram_arbiter dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
      .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rd(input logic [19:0] a);
      int k;
      k = int'(a);
      if (mem.exists(k)) return mem[k];
      return a[15:0] ^ 16'h5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_strobes"}, {sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 4'b0111);
      chk({tag, "_pulses"}, {vid_ack, vid_rvalid, host_ack, host_rvalid}, 4'b0000);
      chk({tag, "_addr"}, sram_addr, 20'h0);
      chk({tag, "_dq_out"}, sram_dq_out, 16'h0);
      chk({tag, "_rdata"}, {vid_rdata, host_rdata}, 32'h0);
   endtask

   // SRAM model: write while we_n is low, present read data while ce_n/oe_n are low
   always @(negedge clk) begin
      if (reset && !sram_we_n && !sram_ce_n && sram_dq_oe) mem[int'(sram_addr)] = sram_dq_out;
      sram_dq_in = (!sram_ce_n && !sram_oe_n) ? rd(sram_addr) : 16'h0000;
   end

   // Scoreboard and bus-rule monitor
   always @(negedge clk) begin
      chk("bus_rule", (!sram_we_n && !sram_dq_oe) || (sram_dq_oe && !sram_oe_n), 1'b0);
      if (vid_rvalid) begin
         checks++;
         assert (vq.size() != 0) else begin
            failures++;
            $error("FAIL vid_rvalid_unexpected: observed=1 expected=0");
         end
         if (vq.size() != 0) chk("vid_rdata", vid_rdata, vq.pop_front());
      end
      if (host_rvalid) begin
         checks++;
         assert (hq.size() != 0) else begin
            failures++;
            $error("FAIL host_rvalid_unexpected: observed=1 expected=0");
         end
         if (hq.size() != 0) chk("host_rdata", host_rdata, hq.pop_front());
      end
   end

   initial begin
      int  nv;
      int  last;
      bit  got;
      mem[32'h10] = 16'hBEEF;

      // reset held with requests active
      vid_req = 1'b1; vid_addr = 20'h00010;
      host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00055; host_wdata = 16'h1234;
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs("t1_reset");
      end
      vid_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("t1_idle_ce_n", sram_ce_n, 1'b1);

      // single video read
      vid_req = 1'b1; vid_addr = 20'h00010; vq.push_back(16'hBEEF);
      @(negedge clk);
      chk("t2_ack", vid_ack, 1'b1);
      chk("t2_oe_n_rd1", sram_oe_n, 1'b0);
      chk("t2_addr", sram_addr, 20'h00010);
      vid_req = 1'b0;
      @(negedge clk);
      chk("t2_ack_pulse", vid_ack, 1'b0);
      chk("t2_oe_n_rd2", sram_oe_n, 1'b0);
      @(negedge clk);
      chk("t2_rvalid", vid_rvalid, 1'b1);
      chk("t2_oe_n_idle", sram_oe_n, 1'b1);
      @(negedge clk);

      // simultaneous requests: video first, host at next arbitration edge
      vid_req = 1'b1; vid_addr = 20'h00300; vq.push_back(rd(20'h00300));
      host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00200; hq.push_back(rd(20'h00200));
      @(negedge clk);
      chk("t3_vid_ack", {vid_ack, host_ack}, 2'b10);
      vid_req = 1'b0;
      @(negedge clk);
      chk("t3_host_wait", host_ack, 1'b0);
      @(negedge clk);
      chk("t3_vid_rvalid", vid_rvalid, 1'b1);
      chk("t3_host_ack", host_ack, 1'b1);
      host_req = 1'b0;
      @(negedge clk);
      chk("t3_host_rvalid_early", host_rvalid, 1'b0);
      @(negedge clk);
      chk("t3_host_rvalid", host_rvalid, 1'b1);
      @(negedge clk);

      // starvation: two rounds of 8 video grants then one host grant
      vid_req = 1'b1; vid_addr = 20'h00040; host_we = 1'b0; host_addr = 20'h00080;
      last = -1;
      for (int r = 0; r < 2; r++) begin
         host_req = 1'b1; nv = 0; got = 1'b0;
         for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (vid_ack) begin
               vq.push_back(rd(20'h00040)); nv++;
               if (last >= 0) chk("t4_gap", c - last, 2);
               last = c;
            end
            if (host_ack) begin
               hq.push_back(rd(20'h00080)); host_req = 1'b0; got = 1'b1;
               if (last >= 0) chk("t4_gap", c - last, 2);
               last = -1;
            end
         end
         chk("t4_host_granted", got, 1'b1);
         chk("t4_vid_before_host", nv, 8);
         repeat (4) begin
            @(negedge clk);
            if (vid_ack) vq.push_back(rd(20'h00040));
         end
         last = -1;
      end
      vid_req = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (vid_ack) vq.push_back(rd(20'h00040));
      end

      // host write followed by a video read: one TURN cycle
      host_req = 1'b1; host_we = 1'b1; host_addr = 20'h12345; host_wdata = 16'hA5A5;
      @(negedge clk);
      chk("t5_host_ack", host_ack, 1'b1);
      chk("t5_wr1_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0101);
      chk("t5_addr", sram_addr, 20'h12345);
      chk("t5_dq_out", sram_dq_out, 16'hA5A5);
      host_req = 1'b0; host_we = 1'b0;
      vid_req = 1'b1; vid_addr = 20'h12345; vq.push_back(16'hA5A5);
      @(negedge clk);
      chk("t5_wr2_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0111);
      chk("t5_no_ack_wr2", vid_ack, 1'b0);
      @(negedge clk);
      chk("t5_turn_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
      chk("t5_no_ack_turn", vid_ack, 1'b0);
      @(negedge clk);
      chk("t5_vid_ack", vid_ack, 1'b1);
      chk("t5_rd1_oe_n", sram_oe_n, 1'b0);
      vid_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_rvalid", vid_rvalid, 1'b1);
      chk("t5_mem", rd(20'h12345), 16'hA5A5);
      @(negedge clk);

      // reset during RD1 aborts the read
      vid_req = 1'b1; vid_addr = 20'h00020;
      @(negedge clk);
      chk("t6_ack", vid_ack, 1'b1);
      chk("t6_rd1_oe_n", sram_oe_n, 1'b0);
      vid_req = 1'b0;
      #1 reset = 1'b0;
      #1 check_reset_outputs("t6_async");
      repeat (2) @(negedge clk);
      check_reset_outputs("t6_held");
      reset = 1'b1;
      repeat (6) @(negedge clk);

      chk("end_vq_empty", vq.size(), 0);
      chk("end_hq_empty", hq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
